// File: rtl/imm_gen_stage.sv
// Immediate generator stage: assembles a 32-bit immediate from the raw instruction and its
// imm_type, registered behind a valid/ready handshake. Define IMM_GEN_SKID_EN for a 2-entry skid buffer.
package imm_gen_pkg;
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_C    = 3'd6
  } imm_type_t;
endpackage

module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  imm_type_t        in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_imm,
  output imm_type_t        out_imm_type,
  output logic [TAG_W-1:0] out_tag
);

  logic [31:0]      imm_d;
  logic             accept;

  logic             main_vld_q, main_vld_d;
  logic [31:0]      main_imm_q, main_imm_d;
  imm_type_t        main_type_q, main_type_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;

  always_comb begin
    imm_d = 32'h0;
    case (in_imm_type)
      IMM_I:   imm_d = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm_d = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm_d = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      IMM_U:   imm_d = {in_instr[31:12], 12'b0};
      IMM_J:   imm_d = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      IMM_C:   imm_d = {27'b0, in_instr[19:15]};
      default: imm_d = 32'h0;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef IMM_GEN_SKID_EN
  logic             skid_vld_q, skid_vld_d;
  logic [31:0]      skid_imm_q, skid_imm_d;
  imm_type_t        skid_type_q, skid_type_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  // Skid occupancy is a flop, so in_ready has no path from out_ready.
  assign in_ready = !skid_vld_q;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_imm_d  = main_imm_q;
    main_type_d = main_type_q;
    main_tag_d  = main_tag_q;
    skid_vld_d  = skid_vld_q;
    skid_imm_d  = skid_imm_q;
    skid_type_d = skid_type_q;
    skid_tag_d  = skid_tag_q;
    if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_imm_d  = skid_imm_q;
        main_type_d = skid_type_q;
        main_tag_d  = skid_tag_q;
        skid_vld_d  = 1'b0;
      end else if (accept) begin
        main_vld_d  = 1'b1;
        main_imm_d  = imm_d;
        main_type_d = in_imm_type;
        main_tag_d  = in_tag;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_imm_d  = imm_d;
      skid_type_d = in_imm_type;
      skid_tag_d  = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid_vld_q  <= 1'b0;
      skid_imm_q  <= 32'h0;
      skid_type_q <= IMM_NONE;
      skid_tag_q  <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_imm_q  <= skid_imm_d;
      skid_type_q <= skid_type_d;
      skid_tag_q  <= skid_tag_d;
    end
  end
`else
  assign in_ready = !main_vld_q || out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_imm_d  = main_imm_q;
    main_type_d = main_type_q;
    main_tag_d  = main_tag_q;
    if (accept) begin
      main_vld_d  = 1'b1;
      main_imm_d  = imm_d;
      main_type_d = in_imm_type;
      main_tag_d  = in_tag;
    end else if (out_ready) begin
      main_vld_d  = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_vld_q  <= 1'b0;
      main_imm_q  <= 32'h0;
      main_type_q <= IMM_NONE;
      main_tag_q  <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_imm_q  <= main_imm_d;
      main_type_q <= main_type_d;
      main_tag_q  <= main_tag_d;
    end
  end

  assign out_valid    = main_vld_q;
  assign out_imm      = main_imm_q;
  assign out_imm_type = main_type_q;
  assign out_tag      = main_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: queue-based occupancy model checked every cycle plus directed
// literal expectations. Honours IMM_GEN_SKID_EN for the in_ready expectations.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  imm_type_t   in_imm_type;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  imm_type_t   out_imm_type;
  logic [31:0] out_tag;

  imm_gen_stage #(.TAG_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_imm_type(out_imm_type), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    imm_type_t   typ;
    logic [31:0] tag;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] outlog[$];
  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 0;

`ifdef IMM_GEN_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value from the ISA field layout, computed as plain integers.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input imm_type_t t);
    int unsigned u;
    int v;
    u = w;
    v = 0;
    case (t)
      IMM_I: begin v = int'(u >> 20); if (v >= 2048) v -= 4096; end
      IMM_S: begin
        v = int'(((u >> 25) & 127) * 32 + ((u >> 7) & 31));
        if (v >= 2048) v -= 4096;
      end
      IMM_B: begin
        v = int'(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 +
                 ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2);
        if (v >= 4096) v -= 8192;
      end
      IMM_U: v = int'(u & 32'hFFFFF000);
      IMM_J: begin
        v = int'(((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096 +
                 ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2);
        if (v >= 1048576) v -= 2097152;
      end
      IMM_C: v = int'((u >> 15) & 31);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit model_rdy();
    if (SKID) return mq.size() < 2;
    return mq.size() == 0 || out_ready;
  endfunction

  // Model state update on each edge.
  always @(posedge clk) begin
    bit ofire, ifire;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
    end else begin
      ofire = (mq.size() > 0) && out_ready;
      ifire = in_valid && model_rdy();
      if (ofire) begin
        outlog.push_back(mq[0].tag);
        void'(mq.pop_front());
      end
      if (ifire) begin
        e.imm = ref_imm(in_instr, in_imm_type);
        e.typ = in_imm_type;
        e.tag = in_tag;
        mq.push_back(e);
      end
    end
  end

  // Compare process, mid-cycle while everything is stable.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(model_rdy()));
      if (mq.size() > 0) begin
        chk("out_imm", out_imm, mq[0].imm);
        chk("out_imm_type", 32'(out_imm_type), 32'(mq[0].typ));
        chk("out_tag", out_tag, mq[0].tag);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input imm_type_t t,
                       input logic [31:0] tg, input logic ordy);
    in_valid = v; in_instr = w; in_imm_type = t; in_tag = tg; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Present an entry, note whether it is taken on the coming edge.
  task automatic offer(input logic v, input logic [31:0] w, input logic [31:0] tg,
                       input logic ordy, output bit acc);
    in_valid = v; in_instr = w; in_imm_type = IMM_I; in_tag = tg; out_ready = ordy;
    #1;
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] src_w[3];
  logic [31:0] src_t[3];

  initial begin
    int idx;
    int budget;
    bit acc;
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, IMM_NONE, 32'h0, 1'b0);
    drive(1'b0, 32'h0, IMM_NONE, 32'h0, 1'b0);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_imm_type", 32'(out_imm_type), 32'(IMM_NONE));
    chk("rst_out_tag", out_tag, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk_en = 1'b1;

    drive(1'b1, 32'hFFF00093, IMM_I, 32'd1, 1'b1);
    chk("addi_valid", 32'(out_valid), 32'h1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_tag", out_tag, 32'd1);
    drive(1'b1, 32'hFE20AE23, IMM_S, 32'd2, 1'b1);
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    drive(1'b1, 32'h123452B7, IMM_U, 32'd3, 1'b1);
    chk("lui_imm", out_imm, 32'h12345000);
    drive(1'b1, 32'h0080006F, IMM_J, 32'd4, 1'b1);
    chk("jal_imm", out_imm, 32'h00000008);
    chk("jal_valid", 32'(out_valid), 32'h1);
    drive(1'b1, 32'h3002D073, IMM_C, 32'd5, 1'b1);
    chk("csr_imm", out_imm, 32'h00000005);
    drive(1'b1, 32'h3002D073, IMM_NONE, 32'd6, 1'b1);
    chk("none_imm", out_imm, 32'h0);
    drive(1'b1, 32'hFE000EE3, IMM_B, 32'd7, 1'b1);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    drive(1'b1, 32'hFFFFFFFF, imm_type_t'(3'd7), 32'd8, 1'b1);
    chk("undef_imm", out_imm, 32'h0);
    drive(1'b0, 32'h0, IMM_NONE, 32'd0, 1'b1);
    chk("idle_valid", 32'(out_valid), 32'h0);

    // Backpressure: three entries offered while the output stalls.
    src_w[0] = 32'h00100093; src_t[0] = 32'd10;
    src_w[1] = 32'h7FF00093; src_t[1] = 32'd11;
    src_w[2] = 32'h80000093; src_t[2] = 32'd12;
    outlog.delete();
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      offer(1'b1, src_w[idx], src_t[idx], 1'b0, acc);
      if (acc) idx++;
      if (c == 0) chk("bp_rdy_after_first", 32'(in_ready), SKID ? 32'h1 : 32'h0);
      if (c == 1) chk("bp_rdy_after_second", 32'(in_ready), 32'h0);
      chk("bp_hold_imm", out_imm, 32'h00000001);
      chk("bp_hold_tag", out_tag, 32'd10);
    end
    chk("bp_accepted", 32'(idx), SKID ? 32'd2 : 32'd1);
    budget = 0;
    while ((idx < 3 || mq.size() > 0) && budget < 20) begin
      if (idx < 3) offer(1'b1, src_w[idx], src_t[idx], 1'b1, acc);
      else offer(1'b0, 32'h0, 32'h0, 1'b1, acc);
      if (acc) idx++;
      budget++;
    end
    chk("bp_drain_timeout", 32'(budget < 20), 32'h1);
    chk("bp_out_count", 32'(outlog.size()), 32'd3);
    if (outlog.size() == 3) begin
      chk("bp_order0", outlog[0], 32'd10);
      chk("bp_order1", outlog[1], 32'd11);
      chk("bp_order2", outlog[2], 32'd12);
    end

    // Flush with entries held and a same-cycle input.
    offer(1'b1, 32'h00100093, 32'd20, 1'b0, acc);
    offer(1'b1, 32'h00200093, 32'd21, 1'b0, acc);
    chk("pre_flush_valid", 32'(out_valid), 32'h1);
    flush = 1'b1;
    drive(1'b1, 32'h00300093, IMM_I, 32'd22, 1'b0);
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_rdy", 32'(in_ready), 32'h1);
    drive(1'b0, 32'h0, IMM_NONE, 32'd0, 1'b0);
    chk("flush_dropped", 32'(out_valid), 32'h0);

    // Reset mid-operation.
    offer(1'b1, 32'h00100093, 32'd30, 1'b0, acc);
    offer(1'b1, 32'h00200093, 32'd31, 1'b0, acc);
    rst = 1'b1;
    drive(1'b1, 32'h00300093, IMM_I, 32'd32, 1'b0);
    rst = 1'b0;
    chk("rst2_valid", 32'(out_valid), 32'h0);
    chk("rst2_imm", out_imm, 32'h0);
    chk("rst2_imm_type", 32'(out_imm_type), 32'(IMM_NONE));
    chk("rst2_tag", out_tag, 32'h0);
    chk("rst2_rdy", 32'(in_ready), 32'h1);
    drive(1'b1, 32'hFFF00093, IMM_I, 32'd40, 1'b1);
    chk("post_rst_imm", out_imm, 32'hFFFFFFFF);
    chk("post_rst_tag", out_tag, 32'd40);
    drive(1'b0, 32'h0, IMM_NONE, 32'd0, 1'b1);
    drive(1'b0, 32'h0, IMM_NONE, 32'd0, 1'b1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
